grid_memory: RTL and testbench
==============================

Name: grid_memory

Overview:
- Cell-occupancy store for the snake playfield; sits directly downstream of the snake/rect controller.
- Accepts the controller's registered cell write word and answers its collision/snack-probe reads with the stored cell function.
- A second read-only port serves the VGA renderer, indexed by pixel coordinates.
- Built-in clear sequencer wipes the grid after reset and on each game (re)start.

Parameters:
GRID_SIZE_X, 32, cells per row
GRID_SIZE_Y, 24, cells per column
RECT_SHIFT, 5, log2 of cell size in pixels (32x32 px cells on 1024x768)
GRID_CELLS, GRID_SIZE_X*GRID_SIZE_Y, memory depth (768)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clear_req  in  1  single-cycle pulse: wipe grid (game start/restart)
rect_write  in  36  {x[35:20], y[19:4], func[3:0]}, presented continuously by controller
rect_read_addr  in  32  {x[31:16], y[15:0]} controller probe address
rect_read_in  out  4  function of probed cell (feeds controller's rect_read_in)
hcount  in  11  renderer pixel x
vcount  in  11  renderer pixel y
disp_func  out  4  function of cell under (hcount, vcount)
busy  out  1  high while clear sequencer runs

Behaviour:
- Function codes: NULL=4'b0000, SNAKE=4'b0001, ROCK=4'b0010, SNACK=4'b0100. All other codes are reserved.
- Cell address = y*GRID_SIZE_X + x. A coordinate is in range iff x < GRID_SIZE_X and y < GRID_SIZE_Y, compared on the full 16-bit fields. 16'hFFFF from a left/up wrap is therefore out of range.
- FSM states: CLEAR and RUN. Reset (async) forces CLEAR with clear counter = 0.
- CLEAR:
  - Writes NULL to cell[counter] each cycle; counter increments.
  - When counter = GRID_CELLS-1 is written, next state is RUN. Clear takes exactly GRID_CELLS cycles after reset release.
  - busy=1 throughout.
  - rect_write is ignored.
  - Both read ports return NULL.
- RUN:
  - Every cycle, rect_write is committed to its cell if coordinates are in range and func is a defined code.
  - Otherwise the cycle is a no-op.
  - Repeated identical words are idempotent and need no enable.
- clear_req:
  - In RUN: enters CLEAR at counter 0 on the next cycle.
  - In CLEAR: restarts counter at 0.
  - clear_req and a valid rect_write in the same RUN cycle: the write commits, then the clear begins.
- Controller read port:
  - rect_read_in is registered, 1-cycle latency.
  - Out-of-range address returns ROCK, so leaving the field is a collision.
  - Read-first: a same-cycle write to the same cell returns the old value.
- Display port:
  - cell x = hcount[RECT_SHIFT+4:RECT_SHIFT], cell y = vcount[RECT_SHIFT+4:RECT_SHIFT].
  - disp_func is registered, 1-cycle latency; the renderer compensates.
  - hcount >= GRID_SIZE_X<<RECT_SHIFT or vcount >= GRID_SIZE_Y<<RECT_SHIFT returns NULL.
  - Read-first, same as the controller port.
- Reset values: rect_read_in=0, disp_func=0, busy=1, state=CLEAR, counter=0. Memory contents are undefined until the first clear completes.
- Memory array has no reset; it must infer as block/distributed RAM with 1 write + 2 read ports.

Optional Feature:
- Macro GRID_BORDER_ROCK_EN.
- Defined: the clear sequencer writes ROCK instead of NULL to every cell with x==0, x==GRID_SIZE_X-1, y==0 or y==GRID_SIZE_Y-1, giving a walled arena. Interior cells are cleared to NULL and cycle count is unchanged.
- Undefined: every cell is cleared to NULL. Walls exist only through the out-of-range ROCK read.

Test Plan:
- Release rst; count cycles -> busy high exactly 768 cycles, then low. Probe (5,5) -> rect_read_in=NULL one cycle after address applied.
- RUN, rect_write={16'd15,16'd15,SNAKE}; next cycle probe (15,15) -> SNAKE. hcount=480, vcount=480 -> disp_func=SNAKE one cycle later.
- Probe x=16'hFFFF,y=3 and x=32,y=0 -> ROCK. rect_write to (40,2) and func=4'b1000 -> no cell changes (full-grid readback).
- Same cycle: write SNACK to (7,7) and probe (7,7), prior NULL -> returns NULL; following cycle -> SNACK.
- Fill cells with SNAKE, pulse clear_req, re-pulse at clear cycle 100 -> busy stays high 768 cycles from second pulse; all cells NULL afterwards. Assert rst mid-clear -> busy=1, counter restarts at 0.
- With GRID_BORDER_ROCK_EN: after clear, (0,10),(31,0),(10,23) -> ROCK; (1,1) -> NULL.

Source files
------------

// File: rtl/grid_memory_if.sv
// Bus between the snake/rect controller plus VGA renderer and the grid_memory cell store.
// The controller/renderer side uses the master modport and grid_memory uses the slave modport.
interface grid_memory_if;
  logic        clear_req;
  logic [35:0] rect_write;
  logic [31:0] rect_read_addr;
  logic [3:0]  rect_read_in;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [3:0]  disp_func;
  logic        busy;

  modport master (
    output clear_req, rect_write, rect_read_addr, hcount, vcount,
    input  rect_read_in, disp_func, busy
  );

  modport slave (
    input  clear_req, rect_write, rect_read_addr, hcount, vcount,
    output rect_read_in, disp_func, busy
  );
endinterface

// File: rtl/grid_memory.sv
// Cell-occupancy store for the snake playfield: one controller write port, a controller probe
// read port, a renderer read port, and a clear sequencer. Optional macro GRID_BORDER_ROCK_EN walls the arena.
module grid_memory #(
  parameter int GRID_SIZE_X = 32,
  parameter int GRID_SIZE_Y = 24,
  parameter int RECT_SHIFT  = 5,
  parameter int GRID_CELLS  = GRID_SIZE_X * GRID_SIZE_Y
) (
  input  logic          clk,
  input  logic          rst,
  grid_memory_if.slave  bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [3:0] FUNC_NULL  = 4'b0000;
  localparam logic [3:0] FUNC_SNAKE = 4'b0001;
  localparam logic [3:0] FUNC_ROCK  = 4'b0010;
  localparam logic [3:0] FUNC_SNACK = 4'b0100;

  localparam int ADDR_W = $clog2(GRID_CELLS);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(GRID_CELLS - 1);
  localparam logic [15:0] X_LIMIT = 16'(GRID_SIZE_X);
  localparam logic [15:0] Y_LIMIT = 16'(GRID_SIZE_Y);
  localparam logic [10:0] H_LIMIT = 11'(GRID_SIZE_X << RECT_SHIFT);
  localparam logic [10:0] V_LIMIT = 11'(GRID_SIZE_Y << RECT_SHIFT);

  logic [3:0] mem [GRID_CELLS];

  state_t            state, state_n;
  logic [ADDR_W-1:0] counter, counter_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [3:0]        wdata;
  logic [3:0]        clear_func;
  logic [3:0]        rect_read_q;
  logic [3:0]        disp_func_q;

  // Controller write word decode
  logic [15:0]       wr_x, wr_y;
  logic [3:0]        wr_func;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;

  assign wr_x    = bus.rect_write[35:20];
  assign wr_y    = bus.rect_write[19:4];
  assign wr_func = bus.rect_write[3:0];
  assign wr_addr = ADDR_W'(32'(wr_y) * GRID_SIZE_X + 32'(wr_x));
  assign wr_valid = (wr_x < X_LIMIT) && (wr_y < Y_LIMIT) &&
                    ((wr_func == FUNC_NULL) || (wr_func == FUNC_SNAKE) ||
                     (wr_func == FUNC_ROCK) || (wr_func == FUNC_SNACK));

  // Controller probe decode
  logic [15:0]       rd_x, rd_y;
  logic              rd_in_range;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_x        = bus.rect_read_addr[31:16];
  assign rd_y        = bus.rect_read_addr[15:0];
  assign rd_in_range = (rd_x < X_LIMIT) && (rd_y < Y_LIMIT);
  assign rd_addr     = ADDR_W'(32'(rd_y) * GRID_SIZE_X + 32'(rd_x));

  // Renderer decode: pixel coordinates down to cell coordinates
  logic [4:0]        disp_x, disp_y;
  logic              disp_in_range;
  logic [ADDR_W-1:0] disp_addr;

  assign disp_x        = bus.hcount[RECT_SHIFT+4:RECT_SHIFT];
  assign disp_y        = bus.vcount[RECT_SHIFT+4:RECT_SHIFT];
  assign disp_in_range = (bus.hcount < H_LIMIT) && (bus.vcount < V_LIMIT);
  assign disp_addr     = ADDR_W'(32'(disp_y) * GRID_SIZE_X + 32'(disp_x));

`ifdef GRID_BORDER_ROCK_EN
  localparam int CX_W = $clog2(GRID_SIZE_X);
  localparam int CY_W = $clog2(GRID_SIZE_Y);
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(GRID_SIZE_X - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(GRID_SIZE_Y - 1);

  // Row/column of the cell being cleared, tracked alongside counter to avoid a divider
  logic [CX_W-1:0] clr_x, clr_x_n;
  logic [CY_W-1:0] clr_y, clr_y_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_x <= '0;
      clr_y <= '0;
    end else begin
      clr_x <= clr_x_n;
      clr_y <= clr_y_n;
    end
  end

  always_comb begin
    clr_x_n = clr_x;
    clr_y_n = clr_y;
    if ((state == RUN) || bus.clear_req || (counter == CELL_LAST)) begin
      clr_x_n = '0;
      clr_y_n = '0;
    end else if (clr_x == CX_LAST) begin
      clr_x_n = '0;
      clr_y_n = clr_y + 1'b1;
    end else begin
      clr_x_n = clr_x + 1'b1;
    end
  end

  assign clear_func = ((clr_x == '0) || (clr_x == CX_LAST) ||
                       (clr_y == '0) || (clr_y == CY_LAST)) ? FUNC_ROCK : FUNC_NULL;
`else
  assign clear_func = FUNC_NULL;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      counter <= '0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
    end
  end

  // In RUN a clear_req still lets the same-cycle write commit before the wipe starts
  always_comb begin
    state_n   = state;
    counter_n = counter;
    we        = 1'b0;
    waddr     = wr_addr;
    wdata     = wr_func;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = counter;
        wdata = clear_func;
        if (bus.clear_req) begin
          counter_n = '0;
        end else if (counter == CELL_LAST) begin
          state_n   = RUN;
          counter_n = '0;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
      RUN: begin
        we = wr_valid;
        if (bus.clear_req) begin
          state_n   = CLEAR;
          counter_n = '0;
        end
      end
      default: begin
        state_n   = CLEAR;
        counter_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Both read ports are read-first; leaving the field reads as a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rect_read_q <= FUNC_NULL;
    end else if (state == CLEAR) begin
      rect_read_q <= FUNC_NULL;
    end else if (!rd_in_range) begin
      rect_read_q <= FUNC_ROCK;
    end else begin
      rect_read_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_func_q <= FUNC_NULL;
    end else if ((state == CLEAR) || !disp_in_range) begin
      disp_func_q <= FUNC_NULL;
    end else begin
      disp_func_q <= mem[disp_addr];
    end
  end

  assign bus.rect_read_in = rect_read_q;
  assign bus.disp_func    = disp_func_q;
  assign bus.busy         = (state == CLEAR);

endmodule

// File: tb/tb_grid_memory.sv
// Directed self-checking bench for grid_memory against a shadow cell model.
// Honours GRID_BORDER_ROCK_EN when the bench is built with the same define as the design.
module tb_grid_memory;

  localparam int GX = 32;
  localparam int GY = 24;
  localparam int CELLS = GX * GY;
  localparam logic [3:0] F_NULL  = 4'b0000;
  localparam logic [3:0] F_SNAKE = 4'b0001;
  localparam logic [3:0] F_ROCK  = 4'b0010;
  localparam logic [3:0] F_SNACK = 4'b0100;
  localparam logic [35:0] PARK_WR = {16'hFFFF, 16'hFFFF, 4'b0000};

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [3:0] model [CELLS];

  grid_memory_if bus();

  grid_memory dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One clock with the given write word and probe address, then the write word is parked
  task automatic applyStimulus(input logic [35:0] wr, input logic [31:0] rd);
    bus.rect_write     = wr;
    bus.rect_read_addr = rd;
    @(posedge clk);
    #1;
    bus.rect_write = PARK_WR;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseClear();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (bus.busy && n < 2000) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [3:0] clearValue(input int x, input int y);
`ifdef GRID_BORDER_ROCK_EN
    if (x == 0 || x == GX - 1 || y == 0 || y == GY - 1) return F_ROCK;
`endif
    return F_NULL;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < CELLS; i++) model[i] = clearValue(i % GX, i / GX);
  endtask

  // Walks every cell through both read ports; pixel offsets inside a cell must not matter
  task automatic readbackAll(input string tag);
    for (int i = 0; i < CELLS; i++) begin
      bus.hcount = 11'((i % GX) * 32 + 17);
      bus.vcount = 11'((i / GX) * 32 + 9);
      applyStimulus(PARK_WR, {16'(i % GX), 16'(i / GX)});
      checkOutput($sformatf("%s_probe_%0d", tag, i), 32'(bus.rect_read_in), 32'(model[i]));
      checkOutput($sformatf("%s_disp_%0d", tag, i), 32'(bus.disp_func), 32'(model[i]));
    end
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.clear_req      = 1'b0;
    bus.rect_write     = PARK_WR;
    bus.rect_read_addr = 32'd0;
    bus.hcount         = 11'd0;
    bus.vcount         = 11'd0;

    tick();
    tick();
    checkOutput("reset_busy", 32'(bus.busy), 32'd1);
    checkOutput("reset_rect_read_in", 32'(bus.rect_read_in), 32'd0);
    checkOutput("reset_disp_func", 32'(bus.disp_func), 32'd0);

    rst = 1'b0;
    countBusy(n);
    checkOutput("initial_clear_cycles", 32'(n), 32'd768);
    checkOutput("run_busy_low", 32'(bus.busy), 32'd0);
    clearModel();

    applyStimulus(PARK_WR, {16'd5, 16'd5});
    checkOutput("probe_5_5", 32'(bus.rect_read_in), 32'(F_NULL));

    applyStimulus({16'd15, 16'd15, F_SNAKE}, {16'd0, 16'd1});
    model[15 * GX + 15] = F_SNAKE;
    applyStimulus(PARK_WR, {16'd15, 16'd15});
    checkOutput("probe_15_15", 32'(bus.rect_read_in), 32'(F_SNAKE));
    bus.hcount = 11'd480;
    bus.vcount = 11'd480;
    tick();
    checkOutput("disp_480_480", 32'(bus.disp_func), 32'(F_SNAKE));

    applyStimulus(PARK_WR, {16'hFFFF, 16'd3});
    checkOutput("probe_wrap_x", 32'(bus.rect_read_in), 32'(F_ROCK));
    applyStimulus(PARK_WR, {16'd32, 16'd0});
    checkOutput("probe_x32", 32'(bus.rect_read_in), 32'(F_ROCK));
    applyStimulus(PARK_WR, {16'd0, 16'd24});
    checkOutput("probe_y24", 32'(bus.rect_read_in), 32'(F_ROCK));
    bus.hcount = 11'd1024;
    bus.vcount = 11'd480;
    tick();
    checkOutput("disp_h1024", 32'(bus.disp_func), 32'(F_NULL));
    bus.hcount = 11'd480;
    bus.vcount = 11'd768;
    tick();
    checkOutput("disp_v768", 32'(bus.disp_func), 32'(F_NULL));
    applyStimulus({16'd31, 16'd23, F_SNACK}, {16'd0, 16'd0});
    model[23 * GX + 31] = F_SNACK;
    bus.hcount = 11'd1023;
    bus.vcount = 11'd767;
    tick();
    checkOutput("disp_last_cell", 32'(bus.disp_func), 32'(F_SNACK));

    applyStimulus({16'd40, 16'd2, F_SNAKE}, {16'd0, 16'd0});
    applyStimulus({16'd3, 16'd2, 4'b1000}, {16'd0, 16'd0});
    applyStimulus({16'd2, 16'd24, F_SNAKE}, {16'd0, 16'd0});
    applyStimulus({16'hFFFF, 16'd5, F_ROCK}, {16'd0, 16'd0});
    readbackAll("noop");

    applyStimulus({16'd7, 16'd7, F_SNACK}, {16'd7, 16'd7});
    checkOutput("read_first_old", 32'(bus.rect_read_in), 32'(F_NULL));
    model[7 * GX + 7] = F_SNACK;
    applyStimulus(PARK_WR, {16'd7, 16'd7});
    checkOutput("read_first_new", 32'(bus.rect_read_in), 32'(F_SNACK));

    for (int i = 0; i < CELLS; i++) begin
      applyStimulus({16'(i % GX), 16'(i / GX), F_SNAKE}, {16'd0, 16'd0});
      model[i] = F_SNAKE;
    end
    applyStimulus(PARK_WR, {16'd9, 16'd4});
    checkOutput("filled_probe", 32'(bus.rect_read_in), 32'(F_SNAKE));

    pulseClear();
    checkOutput("clear_req_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 99; i++) tick();
    bus.rect_read_addr = {16'd40, 16'd40};
    tick();
    checkOutput("clear_read_null", 32'(bus.rect_read_in), 32'(F_NULL));
    checkOutput("clear_busy_at_100", 32'(bus.busy), 32'd1);
    pulseClear();
    countBusy(n);
    checkOutput("reclear_cycles", 32'(n), 32'd768);
    clearModel();
    readbackAll("cleared");

    applyStimulus({16'd4, 16'd4, F_SNAKE}, {16'd0, 16'd0});
    pulseClear();
    for (int i = 0; i < 50; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midclear_rst_busy", 32'(bus.busy), 32'd1);
    checkOutput("midclear_rst_read", 32'(bus.rect_read_in), 32'd0);
    tick();
    rst = 1'b0;
    countBusy(n);
    checkOutput("rst_restart_cycles", 32'(n), 32'd768);
    applyStimulus(PARK_WR, {16'd4, 16'd4});
    checkOutput("after_rst_clear_4_4", 32'(bus.rect_read_in), 32'(F_NULL));

    applyStimulus(PARK_WR, {16'd0, 16'd10});
    checkOutput("cell_0_10", 32'(bus.rect_read_in), 32'(clearValue(0, 10)));
    applyStimulus(PARK_WR, {16'd31, 16'd0});
    checkOutput("cell_31_0", 32'(bus.rect_read_in), 32'(clearValue(31, 0)));
    applyStimulus(PARK_WR, {16'd10, 16'd23});
    checkOutput("cell_10_23", 32'(bus.rect_read_in), 32'(clearValue(10, 23)));
    applyStimulus(PARK_WR, {16'd1, 16'd1});
    checkOutput("cell_1_1", 32'(bus.rect_read_in), 32'(F_NULL));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
